// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
//
// Purpose:
//   Shares the single-port data_memory between the pipeline MEM stage (port 0)
//   and the loader/debug master (port 1). Port 0 has fixed priority. A
//   starvation guard forces port 1 to win once it has been denied MAX_WAIT
//   consecutive cycles. The winning command is registered onto the memory
//   interface. Read data returns with a one-cycle rvalid pulse on the port
//   that owned the read. A low p0_gnt is the MEM-stage stall source.
//
// Parameters:
//   ADDR_WIDTH - byte address width, forwarded unchanged to the memory
//   DATA_WIDTH - data word width
//   MAX_WAIT   - cycles port 1 may be denied before it is forced (1..15)
//
// Ports:
//   clk, reset_n                    clock (rising edge), async active-low reset
//   p0_req/p0_write/p0_address/p0_write_data   port 0 request and payload
//   p0_gnt                          port 0 accepted this cycle (combinational)
//   p0_rvalid, p0_read_data         port 0 read response
//   p1_*                            same set of signals for port 1
//   mem_write, mem_address, mem_write_data     registered memory command
//   mem_read_data                   combinational read data from memory
// -----------------------------------------------------------------------------
module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  p0_req,
  input  logic                  p0_write,
  input  logic [ADDR_WIDTH-1:0] p0_address,
  input  logic [DATA_WIDTH-1:0] p0_write_data,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_read_data,

  input  logic                  p1_req,
  input  logic                  p1_write,
  input  logic [ADDR_WIDTH-1:0] p1_address,
  input  logic [DATA_WIDTH-1:0] p1_write_data,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_read_data,

  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  typedef enum logic {
    P0_PRIO,
    P1_FORCED
  } arb_state_t;

  arb_state_t state;
  arb_state_t state_next;
  logic [3:0] wait_cnt;
  logic [3:0] wait_next;

  // State register and starvation counter. The counter tracks how many
  // consecutive cycles port 1 has been left waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= P0_PRIO;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  // Grant decode and next-state logic. Grants are held low while reset is
  // asserted so no requester believes it was accepted during reset.
  // Entering P1_FORCED as soon as the counter would reach the limit means
  // port 1 wins on the cycle right after its MAX_WAIT-th denial.
  always_comb begin
    p0_gnt     = 1'b0;
    p1_gnt     = 1'b0;
    wait_next  = 4'd0;
    state_next = state;

    if (reset_n) begin
      case (state)
        P0_PRIO: begin
          p0_gnt = p0_req;
          p1_gnt = p1_req & ~p0_req;
        end
        P1_FORCED: begin
          p1_gnt = p1_req;
          p0_gnt = p0_req & ~p1_req;
        end
        default: begin
          p0_gnt = 1'b0;
          p1_gnt = 1'b0;
        end
      endcase
    end

    if (p1_req && !p1_gnt) begin
      if (wait_cnt >= WAIT_LIMIT) begin
        wait_next = WAIT_LIMIT;
      end else begin
        wait_next = wait_cnt + 4'd1;
      end
    end

    case (state)
      P0_PRIO: begin
        if (wait_next == WAIT_LIMIT) begin
          state_next = P1_FORCED;
        end
      end
      P1_FORCED: begin
        if (p1_gnt || !p1_req) begin
          state_next = P0_PRIO;
        end
      end
      default: state_next = P0_PRIO;
    endcase
  end

  // Command stage. The granted command is presented to memory for one cycle.
  // Without a grant only mem_write drops; address and data hold so the
  // memory inputs do not toggle needlessly. Async reset clears mem_write at
  // once, so a write granted just before reset never commits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else if (p0_gnt) begin
      mem_write      <= p0_write;
      mem_address    <= p0_address;
      mem_write_data <= p0_write_data;
    end else if (p1_gnt) begin
      mem_write      <= p1_write;
      mem_address    <= p1_address;
      mem_write_data <= p1_write_data;
    end else begin
      mem_write      <= 1'b0;
    end
  end

  // Read response tracking. The memory reads combinationally, so the data
  // for a read granted in one cycle is on mem_read_data in the next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
    end else begin
      p0_rvalid <= p0_gnt & ~p0_write;
      p1_rvalid <= p1_gnt & ~p1_write;
    end
  end

  assign p0_read_data = mem_read_data;
  assign p1_read_data = mem_read_data;

  // The two grants are mutually exclusive by construction.
  assert property (@(posedge clk) disable iff (!reset_n) !(p0_gnt && p1_gnt));

endmodule

// File: tb/tb_data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_memory_arbiter
//
// Purpose:
//   Self-checking bench for data_memory_arbiter. A small word memory stands in
//   for data_memory. Directed table vectors cover the basic read/write paths,
//   hand-written sequences cover starvation, mid-operation reset and idle, and
//   a randomized phase is checked against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_data_memory_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_WAIT = 4;

  logic          clk;
  logic          reset_n;
  logic          p0_req, p0_write, p1_req, p1_write;
  logic [AW-1:0] p0_address, p1_address;
  logic [DW-1:0] p0_write_data, p1_write_data;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DW-1:0] p0_read_data, p1_read_data;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;

  int tests_run = 0;
  int failures  = 0;

  data_memory_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_WAIT  (MAX_WAIT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .p0_req        (p0_req),
    .p0_write      (p0_write),
    .p0_address    (p0_address),
    .p0_write_data (p0_write_data),
    .p0_gnt        (p0_gnt),
    .p0_rvalid     (p0_rvalid),
    .p0_read_data  (p0_read_data),
    .p1_req        (p1_req),
    .p1_write      (p1_write),
    .p1_address    (p1_address),
    .p1_write_data (p1_write_data),
    .p1_gnt        (p1_gnt),
    .p1_rvalid     (p1_rvalid),
    .p1_read_data  (p1_read_data),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in data_memory: 64 words, combinational read, write on the edge.
  logic [DW-1:0] mem [64];
  assign mem_read_data = mem[mem_address[7:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[7:2]] = mem_write_data;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic          p0_req;
    logic          p0_write;
    logic [31:0]   p0_addr;
    logic [31:0]   p0_wdata;
    logic          p1_req;
    logic          p1_write;
    logic [31:0]   p1_addr;
    logic [31:0]   p1_wdata;
    logic          e_g0;
    logic          e_g1;
    logic          e_rv0;
    logic          e_rv1;
    logic [31:0]   e_rdata;
    logic          e_mw;
    logic [31:0]   e_maddr;
  } vec_t;

  vec_t vectors [10];

  function automatic vec_t mk(input logic r0, input logic w0, input logic [31:0] a0,
                              input logic [31:0] d0, input logic r1, input logic w1,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input logic g0, input logic g1, input logic rv0,
                              input logic rv1, input logic [31:0] rd, input logic mw,
                              input logic [31:0] ma);
    vec_t v;
    v.p0_req = r0; v.p0_write = w0; v.p0_addr = a0; v.p0_wdata = d0;
    v.p1_req = r1; v.p1_write = w1; v.p1_addr = a1; v.p1_wdata = d1;
    v.e_g0 = g0; v.e_g1 = g1; v.e_rv0 = rv0; v.e_rv1 = rv1;
    v.e_rdata = rd; v.e_mw = mw; v.e_maddr = ma;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    p0_req        = v.p0_req;
    p0_write      = v.p0_write;
    p0_address    = v.p0_addr;
    p0_write_data = v.p0_wdata;
    p1_req        = v.p1_req;
    p1_write      = v.p1_write;
    p1_address    = v.p1_addr;
    p1_write_data = v.p1_wdata;
  endtask

  task automatic idleInputs();
    p0_req = 1'b0; p0_write = 1'b0; p0_address = '0; p0_write_data = '0;
    p1_req = 1'b0; p1_write = 1'b0; p1_address = '0; p1_write_data = '0;
  endtask

  // Port 0 requests every cycle, port 1 raises a read at cycle 0 and holds
  // it until granted. Port 1 must win exactly at cycle MAX_WAIT.
  task automatic starvationSequence(input string tag);
    for (int c = 0; c <= MAX_WAIT + 2; c++) begin
      @(posedge clk); #1;
      p0_req = 1'b1; p0_write = 1'b0; p0_address = 32'd0;
      p1_req = (c <= MAX_WAIT); p1_write = 1'b0; p1_address = 32'd20;
      #1;
      checkOutput($sformatf("%s p0_gnt c%0d", tag, c), 32'(p0_gnt), 32'(c != MAX_WAIT));
      checkOutput($sformatf("%s p1_gnt c%0d", tag, c), 32'(p1_gnt), 32'(c == MAX_WAIT));
      checkOutput($sformatf("%s p0_rvalid c%0d", tag, c), 32'(p0_rvalid),
                  32'(c >= 1 && c != MAX_WAIT + 1));
      checkOutput($sformatf("%s p1_rvalid c%0d", tag, c), 32'(p1_rvalid),
                  32'(c == MAX_WAIT + 1));
    end
    @(posedge clk); #1;
    idleInputs();
  endtask

  // Random-phase model state
  logic [31:0] golden [64];
  int          denied;
  logic        forced, g0, g1, hold0, hold1;
  logic        exp_mw, exp_rv0, exp_rv1, addr_known;
  logic [31:0] exp_rdata, exp_addr;
  int unsigned idx;

  task automatic modelIssue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input int port);
    exp_addr   = addr;
    addr_known = 1'b1;
    if (wr) begin
      golden[addr[7:2]] = data;
      exp_mw = 1'b1;
    end else begin
      exp_rdata = golden[addr[7:2]];
      if (port == 0) exp_rv0 = 1'b1;
      else           exp_rv1 = 1'b1;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[3] = 32'd3;
    mem[5] = 32'd5;

    // Reset state, with requests asserted to show grants stay low.
    reset_n = 1'b0;
    idleInputs();
    p0_req = 1'b1;
    p1_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset p0_gnt", 32'(p0_gnt), 32'd0);
    checkOutput("reset p1_gnt", 32'(p1_gnt), 32'd0);
    checkOutput("reset mem_write", 32'(mem_write), 32'd0);
    checkOutput("reset mem_address", mem_address, 32'd0);
    checkOutput("reset mem_write_data", mem_write_data, 32'd0);
    checkOutput("reset p0_rvalid", 32'(p0_rvalid), 32'd0);
    checkOutput("reset p1_rvalid", 32'(p1_rvalid), 32'd0);
    idleInputs();
    #1 reset_n = 1'b1;

    //                 p0: req wr addr data   p1: req wr addr data   g0 g1 rv0 rv1 rdata mw maddr
    vectors[0] = mk(0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vectors[1] = mk(1, 0, 12, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0);
    vectors[2] = mk(0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1, 0, 3, 0, 12);
    vectors[3] = mk(0, 0, 0,  0, 1, 1, 20, 0, 0, 1, 0, 0, 0, 0, 12);
    vectors[4] = mk(0, 0, 0,  0, 1, 0, 20, 0, 0, 1, 0, 0, 0, 1, 20);
    vectors[5] = mk(0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 20);
    vectors[6] = mk(1, 0, 12, 0, 1, 1, 20, 9, 1, 0, 0, 0, 0, 0, 20);
    vectors[7] = mk(0, 0, 0,  0, 1, 1, 20, 9, 0, 1, 1, 0, 3, 0, 12);
    vectors[8] = mk(0, 0, 0,  0, 1, 0, 20, 0, 0, 1, 0, 0, 0, 1, 20);
    vectors[9] = mk(0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1, 9, 0, 20);

    for (int r = 0; r < 10; r++) begin
      @(posedge clk); #1;
      applyStimulus(vectors[r]);
      #1;
      checkOutput($sformatf("row%0d p0_gnt", r), 32'(p0_gnt), 32'(vectors[r].e_g0));
      checkOutput($sformatf("row%0d p1_gnt", r), 32'(p1_gnt), 32'(vectors[r].e_g1));
      checkOutput($sformatf("row%0d p0_rvalid", r), 32'(p0_rvalid), 32'(vectors[r].e_rv0));
      checkOutput($sformatf("row%0d p1_rvalid", r), 32'(p1_rvalid), 32'(vectors[r].e_rv1));
      checkOutput($sformatf("row%0d mem_write", r), 32'(mem_write), 32'(vectors[r].e_mw));
      checkOutput($sformatf("row%0d mem_address", r), mem_address, vectors[r].e_maddr);
      if (vectors[r].e_rv0)
        checkOutput($sformatf("row%0d p0_read_data", r), p0_read_data, vectors[r].e_rdata);
      if (vectors[r].e_rv1)
        checkOutput($sformatf("row%0d p1_read_data", r), p1_read_data, vectors[r].e_rdata);
    end

    starvationSequence("starve");

    // Write granted, then reset pulled low before the commit edge.
    @(posedge clk); #1;
    p0_req = 1'b1; p0_write = 1'b1; p0_address = 32'd12; p0_write_data = 32'd7;
    #1;
    checkOutput("rst-mid p0_gnt write", 32'(p0_gnt), 32'd1);
    @(posedge clk); #1;
    idleInputs();
    checkOutput("rst-mid mem_write before reset", 32'(mem_write), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("rst-mid mem_write dropped", 32'(mem_write), 32'd0);
    p0_req = 1'b1; p1_req = 1'b1;
    #1;
    checkOutput("rst-mid p0_gnt", 32'(p0_gnt), 32'd0);
    checkOutput("rst-mid p1_gnt", 32'(p1_gnt), 32'd0);
    checkOutput("rst-mid p0_rvalid", 32'(p0_rvalid), 32'd0);
    checkOutput("rst-mid p1_rvalid", 32'(p1_rvalid), 32'd0);
    @(posedge clk); #1;
    checkOutput("rst-mid mem_write held low", 32'(mem_write), 32'd0);
    idleInputs();
    reset_n = 1'b1;
    @(posedge clk); #1;
    p0_req = 1'b1; p0_write = 1'b0; p0_address = 32'd12;
    #1;
    checkOutput("post-rst p0_gnt", 32'(p0_gnt), 32'd1);
    @(posedge clk); #1;
    idleInputs();
    #1;
    checkOutput("post-rst p0_rvalid", 32'(p0_rvalid), 32'd1);
    checkOutput("post-rst addr12 data", p0_read_data, 32'd3);

    // Idle for three cycles, then starvation timing must start from scratch.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      idleInputs();
      #1;
      checkOutput($sformatf("idle%0d p0_gnt", c), 32'(p0_gnt), 32'd0);
      checkOutput($sformatf("idle%0d p1_gnt", c), 32'(p1_gnt), 32'd0);
      checkOutput($sformatf("idle%0d mem_write", c), 32'(mem_write), 32'd0);
      checkOutput($sformatf("idle%0d p0_rvalid", c), 32'(p0_rvalid), 32'd0);
      checkOutput($sformatf("idle%0d p1_rvalid", c), 32'(p1_rvalid), 32'd0);
    end
    starvationSequence("idle-starve");

    // Randomized phase against a transaction-level model: port 1 wins once
    // it has been refused MAX_WAIT cycles in a row, otherwise port 0 wins.
    // Memory contents are tracked in grant order.
    @(posedge clk); #1;
    idleInputs();
    for (int i = 0; i < 64; i++) begin
      mem[i]    = 32'(i * 17 + 1);
      golden[i] = 32'(i * 17 + 1);
    end
    denied = 0; hold0 = 1'b0; hold1 = 1'b0;
    exp_mw = 1'b0; exp_rv0 = 1'b0; exp_rv1 = 1'b0; addr_known = 1'b0;
    exp_rdata = '0; exp_addr = '0;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      if (!hold0) begin
        p0_req        = ($urandom_range(0, 9) < 8);
        p0_write      = 1'($urandom_range(0, 1));
        idx           = $urandom_range(0, 63);
        p0_address    = 32'(idx << 2);
        p0_write_data = $urandom;
      end
      if (!hold1) begin
        p1_req        = ($urandom_range(0, 9) < 5);
        p1_write      = 1'($urandom_range(0, 1));
        idx           = $urandom_range(0, 63);
        p1_address    = 32'(idx << 2);
        p1_write_data = $urandom;
      end
      #1;
      checkOutput($sformatf("rand%0d mem_write", cyc), 32'(mem_write), 32'(exp_mw));
      checkOutput($sformatf("rand%0d p0_rvalid", cyc), 32'(p0_rvalid), 32'(exp_rv0));
      checkOutput($sformatf("rand%0d p1_rvalid", cyc), 32'(p1_rvalid), 32'(exp_rv1));
      if (addr_known)
        checkOutput($sformatf("rand%0d mem_address", cyc), mem_address, exp_addr);
      if (exp_rv0)
        checkOutput($sformatf("rand%0d p0_read_data", cyc), p0_read_data, exp_rdata);
      if (exp_rv1)
        checkOutput($sformatf("rand%0d p1_read_data", cyc), p1_read_data, exp_rdata);

      forced = (denied >= MAX_WAIT);
      g1 = p1_req && (forced || !p0_req);
      g0 = p0_req && !g1;
      checkOutput($sformatf("rand%0d p0_gnt", cyc), 32'(p0_gnt), 32'(g0));
      checkOutput($sformatf("rand%0d p1_gnt", cyc), 32'(p1_gnt), 32'(g1));

      if (p1_req && !g1) denied++;
      else               denied = 0;
      hold0 = p0_req && !g0;
      hold1 = p1_req && !g1;

      exp_mw = 1'b0; exp_rv0 = 1'b0; exp_rv1 = 1'b0;
      if (g0)      modelIssue(p0_write, p0_address, p0_write_data, 0);
      else if (g1) modelIssue(p1_write, p1_address, p1_write_data, 1);
    end
    @(posedge clk); #1;
    idleInputs();
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
